// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response channel of the memory bus controller.
// slave modport faces the controller, master modport faces the requester.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Sequences CPU requests onto an asynchronous-style memory bus with a shared data line.
// Reads and writes take 3 cycles accept-to-response, out-of-range 1 cycle; response held until rsp_ready.
module mem_bus_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mrd,
  output logic              mwr
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept;
  logic              in_range;
  logic              drive_bus;

  assign in_range = (int'(bus.req_addr) < MEM_DEPTH);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (!in_range)       state_d = RESP;
          else if (bus.req_we) state_d = WR_SETUP;
          else                 state_d = RD_ADDR;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = RESP;
      RD_ADDR:  state_d = RD_DATA;
      RD_DATA:  state_d = RESP;
      RESP:     if (bus.rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wdata_q <= bus.req_wdata;
        rdata_q <= '1;
        err_q   <= !in_range;
        // Out-of-range requests never reach the bus, so mem_addr keeps its last value.
        if (in_range) addr_q <= bus.req_addr;
      end
      if (state_q == RD_DATA) rdata_q <= mem_data;
    end
  end

  // Every output is forced to its idle value while rst is high, even mid-transfer.
  assign drive_bus     = !rst && ((state_q == WR_SETUP) || (state_q == WR_PULSE));
  assign mem_data      = drive_bus ? wdata_q : 'z;
  assign mem_addr      = rst ? '0 : addr_q;
  assign mrd           = !rst && ((state_q == RD_ADDR) || (state_q == RD_DATA));
  assign mwr           = !rst && (state_q == WR_PULSE);
  assign bus.req_ready = !rst && (state_q == IDLE);
  assign bus.rsp_valid = !rst && (state_q == RESP);
  assign bus.rsp_rdata = rst ? '1 : rdata_q;
  assign bus.rsp_err   = !rst && err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a memory model on the shared bus and a response scoreboard.
module tb_mem_bus_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 200;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  tri0  [DW-1:0] mem_data;
  logic          mrd;
  logic          mwr;

  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mrd      (mrd),
    .mwr      (mwr)
  );

  always #5 clk = ~clk;

  // Memory on the far side of the bus: drives data only while mrd is high.
  logic [DW-1:0] mem_q [256];
  logic          mem_clear;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= '1;
    end else if (mwr) begin
      mem_q[mem_addr] <= mem_data;
    end
  end

  assign mem_data = mrd ? mem_q[mem_addr] : 'z;

  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] exp_mem [256];
  logic          wr_window = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Bus hygiene on every cycle: no strobe overlap, data line idle unless a write or read owns it.
  always @(negedge clk) begin
    if (!mem_clear) begin
      chk("strobe_overlap", 32'(mrd && mwr), 32'd0);
      if (!mrd && !wr_window) chk("bus_idle", 32'(mem_data), 32'd0);
    end
  end

  // Starts at posedge+1 with the DUT in IDLE; returns at posedge+1 after the response handshake.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int hold, input logic bp_next);
    exp_t e, got;
    logic oor;
    oor           = (int'(addr) >= DEPTH);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
    e.err   = oor;
    e.rdata = (we || oor) ? 8'hFF : exp_mem[addr];
    if (we && !oor) exp_mem[addr] = wdata;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!oor && we) begin
      wr_window = 1'b1;
      @(negedge clk);
      chk("wr_setup_data", 32'(mem_data), 32'(wdata));
      chk("wr_setup_addr", 32'(mem_addr), 32'(addr));
      chk("wr_setup_mwr", 32'(mwr), 32'd0);
      chk("wr_setup_rsp", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_pulse_mwr", 32'(mwr), 32'd1);
      chk("wr_pulse_data", 32'(mem_data), 32'(wdata));
      chk("wr_pulse_addr", 32'(mem_addr), 32'(addr));
      @(posedge clk); #1;
      wr_window = 1'b0;
    end else if (!oor) begin
      @(negedge clk);
      chk("rd_addr_mrd", 32'(mrd), 32'd1);
      chk("rd_addr_addr", 32'(mem_addr), 32'(addr));
      chk("rd_addr_rsp", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rd_data_mrd", 32'(mrd), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_strobes", 32'({mrd, mwr}), 32'd0);
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(got.rdata));
      chk("rsp_err", 32'(bus.rsp_err), 32'(got.err));
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        if (bp_next) begin
          bus.req_valid = 1'b1;
          bus.req_we    = 1'b0;
          bus.req_addr  = 8'h10;
        end
        @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'(got.rdata));
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'hFF;
    rst           = 1'b1;
    mem_clear     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_strobes", 32'({mrd, mwr}), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'hFF);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_clear = 1'b0;

    run_txn(1'b1, 8'h10, 8'h5A, 0, 1'b0);
    chk("mem_after_wr", 32'(mem_q[8'h10]), 32'h5A);
    run_txn(1'b0, 8'h10, 8'h00, 0, 1'b0);
    run_txn(1'b0, 8'h20, 8'h00, 0, 1'b0);

    run_txn(1'b0, 8'd199, 8'h00, 0, 1'b0);
    run_txn(1'b0, 8'd200, 8'h00, 0, 1'b0);
    run_txn(1'b0, 8'd255, 8'h00, 0, 1'b0);
    run_txn(1'b1, 8'd200, 8'h33, 0, 1'b0);
    chk("oor_wr_no_mem", 32'(mem_q[200]), 32'hFF);

    run_txn(1'b1, 8'h40, 8'hA5, 0, 1'b0);
    run_txn(1'b0, 8'h40, 8'h00, 5, 1'b1);
    run_txn(1'b0, 8'h10, 8'h00, 0, 1'b0);

    // Reset lands while the controller sits in WR_SETUP.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h30;
    bus.req_wdata = 8'h77;
    @(negedge clk);
    chk("rw_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    chk("rw_mem_data", 32'(mem_data), 32'd0);
    chk("rw_mwr", 32'(mwr), 32'd0);
    chk("rw_mem_addr", 32'(mem_addr), 32'd0);
    chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_idle_next", 32'(bus.req_ready), 32'd1);
    chk("rw_no_mwr", 32'(mwr), 32'd0);
    chk("rw_mem_kept", 32'(mem_q[8'h30]), 32'hFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(1'b0, 8'h30, 8'h00, 0, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of request and memory address.
REQ-002 SHALL have parameter DATA_W, default 8: width of request, response and memory data.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of valid memory words, addresses 0..MEM_DEPTH-1.
REQ-004 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1: CPU request present.
REQ-007 SHALL have port req_ready  out  1: controller accepts a request this cycle.
REQ-008 SHALL have port req_we  in  1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  ADDR_W: word address.
REQ-010 SHALL have port req_wdata  in  DATA_W: write data.
REQ-011 SHALL have port rsp_valid  out  1: response present.
REQ-012 SHALL have port rsp_ready  in  1: CPU consumes response.
REQ-013 SHALL have port rsp_rdata  out  DATA_W: read data; all-ones for writes and errors.
REQ-014 SHALL have port rsp_err  out  1: address was out of range.
REQ-015 SHALL have port mem_addr  out  ADDR_W: address to memory.
REQ-016 SHALL have port mem_data  inout  DATA_W: shared bidirectional memory data bus.
REQ-017 SHALL have ports mrd and mwr  out  1 each: memory read and write strobes.

Function
REQ-018 SHALL implement FSM states IDLE, WR_SETUP, WR_PULSE, RD_ADDR, RD_DATA, RESP.
REQ-019 SHALL assert req_ready only in IDLE while rst=0; accept on req_valid&&req_ready, latching req_we, req_addr, req_wdata.
REQ-020 SHALL on accept go IDLE->RESP with rsp_err=1, rsp_rdata all-ones and no strobe when req_addr >= MEM_DEPTH.
REQ-021 SHALL on in-range write go IDLE->WR_SETUP->WR_PULSE->RESP, one cycle per state.
REQ-022 SHALL on in-range read go IDLE->RD_ADDR->RD_DATA->RESP, one cycle per state.
REQ-023 SHALL drive mem_addr from the latched address in WR_SETUP, WR_PULSE, RD_ADDR and RD_DATA; hold its last value elsewhere.
REQ-024 SHALL drive mem_data with latched write data only in WR_SETUP and WR_PULSE; high-impedance in all other states and during reset.
REQ-025 SHALL assert mwr only in WR_PULSE and mrd only in RD_ADDR and RD_DATA; mrd and mwr never both high.
REQ-026 SHALL capture mem_data into rsp_rdata on the rising edge that leaves RD_DATA.
REQ-027 SHALL assert rsp_valid only in RESP, holding rsp_rdata and rsp_err stable until rsp_ready; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-028 SHALL ignore req_valid outside IDLE; a request held across a busy period is accepted on the first IDLE cycle.
REQ-029 SHALL give latency accept-edge to rsp_valid of 3 cycles for reads and writes, 1 cycle for out-of-range requests.
REQ-030 SHALL set rsp_err=0 and rsp_rdata all-ones for in-range writes.
REQ-031 SHALL treat address MEM_DEPTH-1 as in range and MEM_DEPTH as out of range; no address wrap.

Reset
REQ-032 SHALL on any rising edge with rst=1 enter IDLE, from any state including mid-transfer, discarding the transaction without a response.
REQ-033 SHALL hold while rst=1: req_ready=0, rsp_valid=0, mrd=0, mwr=0, mem_data high-impedance, rsp_err=0, rsp_rdata all-ones, mem_addr 0.
REQ-034 SHALL accept a request on the first cycle after rst deasserts.

Verification
REQ-035 SHALL verify write then read: write addr 0x10 data 0x5A, then read 0x10 -> mwr one cycle with mem_data=0x5A, then rsp_rdata=0x5A, rsp_err=0, 3-cycle latency each.
REQ-036 SHALL verify unwritten read: read addr 0x20 after reset -> rsp_rdata=0xFF, rsp_err=0.
REQ-037 SHALL verify boundary: MEM_DEPTH=200, read 199 -> rsp_err=0 with mrd pulse; read 200 -> rsp_err=1, rdata 0xFF, no mrd/mwr, rsp_valid one cycle after accept.
REQ-038 SHALL verify backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, second held request accepted the cycle after rsp handshake.
REQ-039 SHALL verify reset in WR_SETUP -> no mwr pulse, memory word unchanged, mem_data high-impedance, IDLE next cycle.
REQ-040 SHALL verify bus hygiene every cycle: mem_data driven only when a write state is active, never mrd&&mwr.
